// File: rtl/conv_bram_1d_result_drain.sv
// Read side of the 1-D conv result RAM.
// On start, reads RESULT_W words from the result BRAM at addresses 0..RESULT_W-1.
// The words are streamed out in order on a valid/ready port.
// A 2-entry FIFO absorbs the one-cycle BRAM latency and downstream stalls.
// Optional feature: define CONV_DRAIN_RELU_EN to clamp negative words to zero at the output.
module conv_bram_1d_result_drain #(
    parameter int DATA_WIDTH            = 8,
    parameter int IMG_W                 = 32,
    parameter int FILTER_L              = 3,
    parameter int STRIDE_W              = 1,
    parameter int RESULT_W              = (IMG_W - FILTER_L) / STRIDE_W + 1,
    parameter int RESULT_RAM_ADDR_WIDTH = (RESULT_W > 1) ? $clog2(RESULT_W) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0] result_rdaddr,
    output logic                             result_rden,
    input  logic [DATA_WIDTH*4-1:0]          result_rddata,
    output logic [DATA_WIDTH*4-1:0]          out_data,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0] out_idx,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last
);

    localparam int WW = DATA_WIDTH * 4;
    localparam int AW = RESULT_RAM_ADDR_WIDTH;
    localparam logic [AW-1:0] LAST_IDX = AW'(RESULT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_ptr;
    logic            r_busy;
    logic            r_done;

    // Read issued last cycle; its data is on result_rddata this cycle
    logic            r_pend;
    logic [AW-1:0]   r_pend_idx;

    logic [WW-1:0]   r_buf_data [2];
    logic [AW-1:0]   r_buf_idx  [2];
    logic            r_wp;
    logic            r_rp;
    logic [1:0]      r_count;

    logic            w_xfer;
    logic            w_issue;
    logic [2:0]      w_credit;
    logic [WW-1:0]   w_head;

    // Slot accounting: occupancy after this cycle's capture/transfer decides whether a new read fits.
    // Crediting the same-cycle transfer is what allows 1 word/cycle with only two entries.
    always_comb begin
        w_xfer   = (r_count != 2'd0) && out_ready;
        w_credit = {1'b0, r_count} + {2'b0, r_pend} - {2'b0, w_xfer};
        w_issue  = (r_state == S_DRAIN) && (w_credit < 3'd2);
        w_head   = r_buf_data[r_rp];
    end

    // Capture returning read data into the FIFO and retire transferred words
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_idx[i]  <= '0;
            end
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_count    <= 2'd0;
            r_pend     <= 1'b0;
            r_pend_idx <= '0;
        end else begin
            if (r_pend) begin
                r_buf_data[r_wp] <= result_rddata;
                r_buf_idx[r_wp]  <= r_pend_idx;
                r_wp             <= ~r_wp;
            end
            if (w_xfer) begin
                r_rp <= ~r_rp;
            end
            r_count <= w_credit[1:0];
            r_pend  <= w_issue;
            if (w_issue) begin
                r_pend_idx <= r_ptr;
            end
        end
    end

    // Control FSM: read pointer, busy and done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_issue) begin
                        if (r_ptr == LAST_IDX) begin
                            r_state <= S_FLUSH;
                        end else begin
                            r_ptr <= r_ptr + AW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    // Zero credit here means the last word is leaving this cycle, so done lands next cycle
                    if (w_credit == 3'd0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign result_rdaddr = r_ptr;
    assign result_rden   = w_issue;
    assign out_valid     = (r_count != 2'd0);
    assign out_idx       = r_buf_idx[r_rp];
    assign out_last      = out_valid && (r_buf_idx[r_rp] == LAST_IDX);

`ifdef CONV_DRAIN_RELU_EN
    assign out_data = w_head[WW-1] ? '0 : w_head;
`else
    assign out_data = w_head;
`endif

endmodule
